// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot decoder sequencer.
package onehot_pkg;

   localparam int IDX_W = 3;
   localparam int OUT_W = 1 << IDX_W;

   typedef enum logic {
      IDLE,
      DRIVE
   } state_t;

   function automatic logic [OUT_W-1:0] decode(input logic [IDX_W-1:0] idx);
      logic [OUT_W-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/onehot_idx_fifo.sv
// Small synchronous index FIFO; push ignored when full, pop ignored when empty.
module onehot_idx_fifo #(
   parameter int W     = 3,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Queued binary-to-one-hot driver with per-entry dwell time.
// Define ONEHOT_GAP_EN for one idle cycle between consecutive patterns.
module onehot_decoder_seq
   import onehot_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DWELL_W    = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [IDX_W-1:0]            in_idx,
   input  logic [DWELL_W-1:0]          dwell,
   output logic [OUT_W-1:0]            onehot_out,
   output logic                        out_active,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

`ifdef ONEHOT_GAP_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif

   state_t             state;
   state_t             state_nxt;
   logic [DWELL_W-1:0] cnt;
   logic [DWELL_W-1:0] cnt_nxt;
   logic [DWELL_W-1:0] load_cnt;
   logic [OUT_W-1:0]   out_nxt;
   logic [IDX_W-1:0]   head;
   logic               full;
   logic               empty;
   logic               pop;

   assign in_ready   = !full;
   assign out_active = |onehot_out;
   assign busy       = (state != IDLE) || !empty;
   assign load_cnt   = (dwell == '0) ? DWELL_W'(1) : dwell;

   onehot_idx_fifo #(
      .W     (IDX_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .pop   (pop),
      .wdata (in_idx),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         onehot_out <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         onehot_out <= out_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      out_nxt   = onehot_out;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               out_nxt   = decode(head);
               cnt_nxt   = load_cnt;
               state_nxt = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt > DWELL_W'(1)) begin
               cnt_nxt = cnt - 1'b1;
            end else if (!empty && !GAP_EN) begin
               // Reload on the expiring edge so patterns abut.
               pop     = 1'b1;
               out_nxt = decode(head);
               cnt_nxt = load_cnt;
            end else begin
               out_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench: queue-based reference model plus directed scenarios.
module tb_onehot_decoder_seq;

`ifdef ONEHOT_GAP_EN
   localparam bit GAP = 1'b1;
`else
   localparam bit GAP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_idx;
   logic [7:0] dwell;
   logic [7:0] onehot_out;
   logic       out_active;
   logic       busy;
   logic [2:0] fifo_level;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   // Reference model: waiting entries plus pattern on display and cycles left.
   logic [2:0] q[$];
   logic [7:0] m_out = 8'h00;
   int         m_rem = 0;

   onehot_decoder_seq dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_idx     (in_idx),
      .dwell      (dwell),
      .onehot_out (onehot_out),
      .out_active (out_active),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic model_reset();
      q.delete();
      m_out = 8'h00;
      m_rem = 0;
   endtask

   task automatic model_step();
      int sz;
      bit acc;
      bit load;
      sz   = q.size();
      acc  = in_valid && (sz < 4);
      load = 1'b0;
      if (m_rem == 0) begin
         load = (sz > 0);
      end else if (m_rem == 1) begin
         if (!GAP && sz > 0) load = 1'b1;
         else begin
            m_out = 8'h00;
            m_rem = 0;
         end
      end else begin
         m_rem--;
      end
      if (load) begin
         m_out = 8'b1 << q.pop_front();
         m_rem = (dwell == 0) ? 1 : int'(dwell);
      end
      if (acc) q.push_back(in_idx);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_step();
      #2;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("onehot", onehot_out, m_out);
         chk("active", out_active, m_out != 0);
         chk("ready", in_ready, q.size() < 4);
         chk("level", fifo_level, q.size());
         chk("busy", busy, (m_rem != 0) || (q.size() != 0));
      end
   end

   initial begin
      int idx;
      int acc6;
      bit rdy;
      int ld[6];
      logic [7:0] exp_bb[4];
      logic [7:0] exp_dw[4];

      rst      = 1'b0;
      in_valid = 1'b0;
      in_idx   = '0;
      dwell    = '0;
      repeat (2) tick();

      // Reset asserted between edges.
      #1 rst = 1'b1;
      model_reset();
      #1;
      chk("rst_onehot", onehot_out, 8'h00);
      chk("rst_active", out_active, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_level", fifo_level, 3'd0);
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("rst_ready", in_ready, 1'b1);

      // Single entry, dwell 3.
      dwell = 8'd3; in_idx = 3'd5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("single_e0", onehot_out, 8'h00);
      for (int e = 1; e <= 4; e++) begin
         tick();
         chk("single_out", onehot_out, (e <= 3) ? 8'h20 : 8'h00);
      end
      chk("single_busy", busy, 1'b0);
      repeat (2) tick();

      // Back-to-back with dwell 0.
      if (GAP) begin
         exp_bb[0] = 8'h01; exp_bb[1] = 8'h00;
         exp_bb[2] = 8'h80; exp_bb[3] = 8'h00;
      end else begin
         exp_bb[0] = 8'h01; exp_bb[1] = 8'h80;
         exp_bb[2] = 8'h00; exp_bb[3] = 8'h00;
      end
      dwell = 8'd0; in_idx = 3'd0; in_valid = 1'b1;
      tick();
      in_idx = 3'd7;
      tick();
      in_valid = 1'b0;
      chk("bb_e1", onehot_out, exp_bb[0]);
      for (int e = 1; e < 4; e++) begin
         tick();
         chk("bb_seq", onehot_out, exp_bb[e]);
      end
      repeat (2) tick();

      // Full FIFO, dwell 10, indices 1..6 offered continuously.
      for (int k = 0; k < 6; k++) ld[k] = 1 + k * (GAP ? 11 : 10);
      dwell = 8'd10;
      idx   = 1;
      acc6  = -1;
      for (int e = 0; e < 70; e++) begin
         in_valid = (idx <= 6);
         in_idx   = 3'(idx);
         rdy      = in_ready;
         tick();
         if (in_valid && rdy) begin
            if (idx == 6) acc6 = e;
            idx++;
         end
         if (e == 4) begin
            chk("full_level", fifo_level, 3'd4);
            chk("full_ready", in_ready, 1'b0);
         end
         for (int k = 0; k < 6; k++)
            if (e == ld[k]) chk("full_order", onehot_out, 8'b1 << (k + 1));
      end
      in_valid = 1'b0;
      chk("full_acc6", acc6, GAP ? 13 : 12);
      chk("full_end", onehot_out, 8'h00);
      chk("full_idle", busy, 1'b0);

      // Dwell changed while an entry is held.
      if (GAP) begin
         exp_dw[0] = 8'h08; exp_dw[1] = 8'h00;
         exp_dw[2] = 8'h40; exp_dw[3] = 8'h00;
      end else begin
         exp_dw[0] = 8'h08; exp_dw[1] = 8'h40;
         exp_dw[2] = 8'h00; exp_dw[3] = 8'h00;
      end
      dwell = 8'd5; in_idx = 3'd3; in_valid = 1'b1;
      tick();
      in_idx = 3'd6;
      tick();
      in_valid = 1'b0;
      tick();
      dwell = 8'd1;
      tick();
      tick();
      tick();
      chk("dwell_e5", onehot_out, exp_dw[0]);
      for (int e = 1; e < 4; e++) begin
         tick();
         chk("dwell_seq", onehot_out, exp_dw[e]);
      end
      repeat (2) tick();

      // Reset while driving with three entries queued.
      dwell = 8'd8; in_valid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         in_idx = 3'(k);
         tick();
      end
      in_valid = 1'b0;
      chk("mid_level", fifo_level, 3'd3);
      chk("mid_out", onehot_out, 8'h02);
      #1 rst = 1'b1;
      model_reset();
      #1;
      chk("mid_rst_out", onehot_out, 8'h00);
      chk("mid_rst_level", fifo_level, 3'd0);
      chk("mid_rst_busy", busy, 1'b0);
      tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("mid_after_out", onehot_out, 8'h00);
      chk("mid_after_busy", busy, 1'b0);

      @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
- Binary-index to one-hot decoder with queuing and timed hold.
- Accepts 3-bit indices over a valid/ready handshake and buffers them in a small FIFO.
- Drives each one as a one-hot 8-bit pattern for a programmable number of cycles.
- Sits on the output side of the one-hot/priority encoding path and drives 8 one-hot lines, e.g. LEDs or segment selects.

Parameters:
- IDX_W, 3, index width.
- OUT_W, 8, one-hot width; must equal 2**IDX_W.
- FIFO_DEPTH, 4, queued index entries; must be a power of 2.
- DWELL_W, 8, width of the dwell-count input and the internal counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  index present on in_idx.
- in_ready  out  1  FIFO can accept; transfer when in_valid && in_ready at a rising edge.
- in_idx  in  IDX_W  binary index to decode.
- dwell  in  DWELL_W  hold time in cycles; sampled when an entry is loaded.
- onehot_out  out  OUT_W  registered one-hot output; all-zero when idle.
- out_active  out  1  high while onehot_out is non-zero.
- busy  out  1  FSM not IDLE, or FIFO not empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Interface is fixed: one clock, clk; reset is asynchronous and active-high, port rst.
- Reset (asynchronous, active-high): the following clear immediately, regardless of clock, and remain cleared while rst is high.
  - onehot_out=0, out_active=0, busy=0, fifo_level=0.
  - FSM goes to IDLE; dwell counter goes to 0.
- in_ready: equals !(fifo_level==FIFO_DEPTH), purely from registered level.
  - A push is never accepted while full, even if a pop occurs in the same cycle.
- FIFO:
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Order is strictly FIFO.
- FSM states: IDLE, DRIVE.
- IDLE:
  - If FIFO is non-empty: pop head, load onehot_out = 1 << idx, and load counter = (dwell==0 ? 1 : dwell). Go to DRIVE.
  - Otherwise onehot_out stays 0.
- DRIVE:
  - onehot_out is held; counter decrements each cycle.
  - At counter==1 with FIFO non-empty: pop and load the next entry in the same edge, so there is no zero gap between patterns. Stay in DRIVE.
  - At counter==1 with FIFO empty: onehot_out<=0 and go to IDLE.
- Latency:
  - An index pushed at edge N into an empty FIFO while IDLE appears on onehot_out after edge N+1.
  - Each entry is visible for exactly max(dwell,1) cycles.
- Dwell is captured at load; changing dwell mid-hold does not affect the current entry.
- out_active equals |onehot_out. Exactly one bit of onehot_out is set whenever it is non-zero.
- Reset mid-DRIVE: the output drops to zero asynchronously and queued entries are discarded.

Optional Feature:
- Macro ONEHOT_GAP_EN.
- When defined (break-before-make):
  - At counter==1 in DRIVE, always go to IDLE with onehot_out<=0, even if the FIFO is non-empty.
  - The next entry loads on the following edge, so consecutive patterns are separated by exactly one all-zero cycle.
- When undefined: back-to-back loading as described under Behaviour.

Decomposition:
- Shared package onehot_pkg holds:
  - IDX_W and OUT_W constants.
  - State typedef (IDLE, DRIVE).
  - A decode function idx -> one-hot.
- One sub-module: onehot_idx_fifo, a synchronous FIFO with push/pop, full/empty and level outputs, using the same clk and rst.
- The FSM, counter and output register stay in onehot_decoder_seq.

Test Plan:
- Reset: assert rst mid-clock -> onehot_out=8'h00, out_active=0, busy=0, fifo_level=0 immediately; in_ready=1 after release.
- Single entry: dwell=3, push idx=5 at edge 0 -> onehot_out=8'h20 after edges 1,2,3; 8'h00 after edge 4; busy low after edge 4.
- Back-to-back with dwell=0 (treated as 1): push idx=0 then idx=7 on consecutive edges.
  - Without ONEHOT_GAP_EN: 8'h01 for one cycle, then 8'h80 for one cycle, no zero gap.
  - With ONEHOT_GAP_EN: 8'h01, 8'h00, 8'h80.
- Full FIFO: dwell=10, in_valid held high with idx 1..6.
  - Five entries are accepted: one popped at edge 1, four queued.
  - in_ready=0 while fifo_level=4.
  - The sixth entry is accepted only after the first retires.
  - Outputs appear in order 8'h02,8'h04,8'h08,8'h10,8'h20,8'h40, each for 10 cycles.
- Dwell change: load idx=3 with dwell=5, change dwell to 1 two cycles later -> 8'h08 still held 5 cycles; the next entry uses dwell=1.
- Reset mid-operation: rst pulse during DRIVE with 3 queued entries -> output 8'h00 at once, fifo_level=0; no queued entry appears after release.
